// File: rtl/mseq_check.sv
// mseq_check: receive-side checker for the team's m-sequence generator.
// A local LFSR is loaded from WIDTH received bits and then free-runs.
// Each later valid bit is compared against the local prediction.
// Lock is declared after LOCK_CNT consecutive correct predictions.
// While locked, errors are counted per WINDOW bits.
// Reaching ERR_THRESH errors within one window drops lock and reloads.
// Optional feature: define MSEQ_ERR_TOTAL_EN to enable the saturating err_total counter.
module mseq_check #(
   parameter int WIDTH      = 4,
   parameter int LOCK_CNT   = 8,
   parameter int WINDOW     = 16,
   parameter int ERR_THRESH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_in,
   input  logic             bit_valid,
   input  logic [WIDTH-1:0] taps,
   output logic             lock,
   output logic             err_pulse,
   output logic [WIDTH-1:0] phase,
   output logic [15:0]      err_total
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [CW-1:0] LOAD_LAST  = CW'(WIDTH - 1);
   localparam logic [7:0]    MATCH_LAST = 8'(LOCK_CNT - 1);
   localparam logic [7:0]    WIN_END    = 8'(WINDOW);
   localparam logic [7:0]    ERR_END    = 8'(ERR_THRESH);

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] phase_n;
   logic [CW-1:0]    load_cnt, load_cnt_n;
   logic [7:0]       match_cnt, match_cnt_n;
   logic [7:0]       win_cnt, win_cnt_n;
   logic [7:0]       err_cnt, err_cnt_n;
   logic             lock_n;
   logic             err_pulse_n;

   logic             fb;
   logic             mismatch;
   logic [WIDTH-1:0] phase_load;
   logic [WIDTH-1:0] phase_run;
   logic [7:0]       win_inc;
   logic [7:0]       err_inc;

   // Prediction and the two candidate next phases (loaded vs free-running)
   always_comb begin
      fb         = ^(phase & taps);
      mismatch   = (bit_in != fb);
      phase_load = {bit_in, phase[WIDTH-1:1]};
      phase_run  = {fb, phase[WIDTH-1:1]};
      win_inc    = win_cnt + 8'd1;
      err_inc    = err_cnt + {7'd0, mismatch};
   end

   // Next-state and next-output logic; nothing moves unless bit_valid is high
   always_comb begin
      state_n     = state;
      phase_n     = phase;
      load_cnt_n  = load_cnt;
      match_cnt_n = match_cnt;
      win_cnt_n   = win_cnt;
      err_cnt_n   = err_cnt;
      lock_n      = lock;
      err_pulse_n = 1'b0;
      if (bit_valid) begin
         case (state)
            ST_LOAD: begin
               phase_n = phase_load;
               if (load_cnt == LOAD_LAST) begin
                  // An all-zero phase is the LFSR lock-up state: reload from scratch
                  load_cnt_n = '0;
                  if (phase_load != '0) begin
                     state_n     = ST_VERIFY;
                     match_cnt_n = '0;
                  end
               end else begin
                  load_cnt_n = load_cnt + CW'(1);
               end
            end
            ST_VERIFY: begin
               phase_n = phase_run;
               if (!mismatch) begin
                  if (match_cnt == MATCH_LAST) begin
                     state_n     = ST_LOCKED;
                     lock_n      = 1'b1;
                     match_cnt_n = '0;
                     win_cnt_n   = '0;
                     err_cnt_n   = '0;
                  end else begin
                     match_cnt_n = match_cnt + 8'd1;
                  end
               end else begin
                  // The bad bit is dropped; LOAD refills the whole phase anyway
                  err_pulse_n = 1'b1;
                  state_n     = ST_LOAD;
                  load_cnt_n  = '0;
                  match_cnt_n = '0;
               end
            end
            ST_LOCKED: begin
               phase_n     = phase_run;
               err_pulse_n = mismatch;
               // Loss of lock takes priority over a simultaneous window end
               if (mismatch && (err_inc == ERR_END)) begin
                  state_n     = ST_LOAD;
                  lock_n      = 1'b0;
                  load_cnt_n  = '0;
                  match_cnt_n = '0;
                  win_cnt_n   = '0;
                  err_cnt_n   = '0;
               end else if (win_inc == WIN_END) begin
                  win_cnt_n = '0;
                  err_cnt_n = '0;
               end else begin
                  win_cnt_n = win_inc;
                  err_cnt_n = err_inc;
               end
            end
            default: begin
               state_n    = ST_LOAD;
               load_cnt_n = '0;
               lock_n     = 1'b0;
            end
         endcase
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_LOAD;
         phase     <= '0;
         load_cnt  <= '0;
         match_cnt <= '0;
         win_cnt   <= '0;
         err_cnt   <= '0;
         lock      <= 1'b0;
         err_pulse <= 1'b0;
      end else begin
         state     <= state_n;
         phase     <= phase_n;
         load_cnt  <= load_cnt_n;
         match_cnt <= match_cnt_n;
         win_cnt   <= win_cnt_n;
         err_cnt   <= err_cnt_n;
         lock      <= lock_n;
         err_pulse <= err_pulse_n;
      end
   end

`ifdef MSEQ_ERR_TOTAL_EN
   logic [15:0] err_total_r;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Lifetime error count, moves together with err_pulse and survives loss of lock
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_total_r <= '0;
      end else if (err_pulse_n) begin
         err_total_r <= sat_inc16(err_total_r);
      end
   end

   assign err_total = err_total_r;
`else
   assign err_total = 16'd0;
`endif

endmodule

// File: tb/tb_mseq_check.sv
// tb_mseq_check: directed bench for mseq_check (WIDTH=4, taps=4'b0011).
// A generator model seeded 4'b1000 produces the stream; errors are injected by inversion.
module tb_mseq_check;

   logic        clk;
   logic        rst;
   logic        bit_in;
   logic        bit_valid;
   logic [3:0]  taps;
   logic        lock;
   logic        err_pulse;
   logic [3:0]  phase;
   logic [15:0] err_total;

   int checks   = 0;
   int failures = 0;
   int ep_cnt   = 0;
   int gap      = 2;
   logic [3:0] g;
   int base;
   int etot_on;

   mseq_check #(
      .WIDTH(4), .LOCK_CNT(8), .WINDOW(16), .ERR_THRESH(3)
   ) dut (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
      .taps(taps), .lock(lock), .err_pulse(err_pulse), .phase(phase),
      .err_total(err_total)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // err_pulse spans exactly one negedge per pulse
   always @(negedge clk) if (err_pulse === 1'b1) ep_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bit_valid = 1'b0;
      bit_in = 1'b0;
      g = 4'b1000;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // One valid bit; returns #1 after the sampling edge with bit_valid already low
   task automatic send_bit(input logic b);
      repeat (gap - 1) @(posedge clk);
      @(negedge clk);
      bit_in = b;
      bit_valid = 1'b1;
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
   endtask

   // Next generator bit (transmitted bit = feedback before the step), optionally inverted
   task automatic send_gen(input logic inv);
      logic b;
      b = ^(g & taps);
      g = {b, g[3:1]};
      send_bit(b ^ inv);
   endtask

   initial begin
`ifdef MSEQ_ERR_TOTAL_EN
      etot_on = 1;
`else
      etot_on = 0;
`endif
      rst = 1'b1;
      bit_in = 1'b0;
      bit_valid = 1'b0;
      taps = 4'b0011;
      g = 4'b1000;
      do_reset();
      @(posedge clk); #1;
      check("rst_lock", {31'd0, lock}, 0);
      check("rst_err_pulse", {31'd0, err_pulse}, 0);
      check("rst_phase", {28'd0, phase}, 0);
      check("rst_err_total", {16'd0, err_total}, 0);

      // Basic lock, bit_valid every 21 clocks
      gap = 21;
      base = ep_cnt;
      for (int i = 1; i <= 12; i++) begin
         send_gen(1'b0);
         if (i >= 10) check($sformatf("basic_lock_bit%0d", i), {31'd0, lock}, (i == 12) ? 1 : 0);
      end
      check("basic_phase", {28'd0, phase}, {28'd0, g});
      repeat (3) @(posedge clk); #1;
      check("basic_phase_hold", {28'd0, phase}, {28'd0, g});
      check("basic_no_err", ep_cnt - base, 0);

      // Verify failure on bit 7, relock after bit 19
      gap = 2;
      do_reset();
      base = ep_cnt;
      for (int i = 1; i <= 19; i++) begin
         send_gen(i == 7);
         if (i == 7) begin
            check("vfail_pulse", {31'd0, err_pulse}, 1);
            check("vfail_lock", {31'd0, lock}, 0);
            @(posedge clk); #1;
            check("vfail_pulse_one_cycle", {31'd0, err_pulse}, 0);
         end
         if (i >= 18) check($sformatf("vfail_lock_bit%0d", i), {31'd0, lock}, (i == 19) ? 1 : 0);
      end
      check("vfail_pulse_count", ep_cnt - base, 1);

      // Loss of lock: errors at window positions 2, 5 and 16 (third one coincides with window end)
      base = ep_cnt;
      for (int i = 1; i <= 16; i++) begin
         send_gen(i == 2 || i == 5 || i == 16);
         if (i == 15) check("lol_lock_before", {31'd0, lock}, 1);
         if (i == 16) begin
            check("lol_lock_fall", {31'd0, lock}, 0);
            check("lol_pulse", {31'd0, err_pulse}, 1);
         end
      end
      @(posedge clk); #1;
      check("lol_pulse_count", ep_cnt - base, 3);
      check("lol_err_total_kept", {16'd0, err_total}, etot_on ? 4 : 0);
      for (int i = 1; i <= 12; i++) begin
         send_gen(1'b0);
         if (i >= 11) check($sformatf("lol_relock_bit%0d", i), {31'd0, lock}, (i == 12) ? 1 : 0);
      end

      // Tolerated errors: two per window (positions 5 and 16) for five windows
      do_reset();
      for (int i = 1; i <= 12; i++) send_gen(1'b0);
      check("tol_locked", {31'd0, lock}, 1);
      base = ep_cnt;
      for (int w = 0; w < 5; w++) begin
         for (int i = 1; i <= 16; i++) begin
            send_gen(i == 5 || i == 16);
            if (lock !== 1'b1) check($sformatf("tol_lock_w%0d_b%0d", w, i), {31'd0, lock}, 1);
         end
      end
      @(posedge clk); #1;
      check("tol_lock_end", {31'd0, lock}, 1);
      check("tol_pulse_count", ep_cnt - base, 10);
      check("tol_err_total", {16'd0, err_total}, etot_on ? 10 : 0);
      check("tol_phase", {28'd0, phase}, {28'd0, g});

      // All-zero load followed by a valid stream
      do_reset();
      base = ep_cnt;
      for (int i = 1; i <= 4; i++) send_bit(1'b0);
      check("zero_phase", {28'd0, phase}, 0);
      for (int i = 1; i <= 12; i++) begin
         send_gen(1'b0);
         if (i >= 11) check($sformatf("zero_lock_bit%0d", i), {31'd0, lock}, (i == 12) ? 1 : 0);
      end
      check("zero_no_err", ep_cnt - base, 0);

      // Asynchronous reset while locked, between clock edges
      send_gen(1'b1);
      check("arst_pre_lock", {31'd0, lock}, 1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_lock", {31'd0, lock}, 0);
      check("arst_phase", {28'd0, phase}, 0);
      check("arst_err_total", {16'd0, err_total}, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
